// File: rtl/ram_rw_sequencer.sv
// ---------------------------------------------------------------------------
// RamRwSequencer (module ram_rw_sequencer)
//
// Purpose:
//   Drives a simple RAM through bursts of read-then-write beats. Each beat
//   reads one address, then writes the same address. A slow RAM may ask for
//   a fixed number of idle cycles after each write. Addresses increment
//   modulo 2^ADDR_W between beats.
//
// Parameters:
//   ADDR_W      - address bus and address counter width
//   BURST_LEN   - beats per transaction (1..2^ADDR_W)
//   WAIT_CYCLES - idle cycles after a slow-RAM write (1..255)
//
// Ports:
//   i_clock     - single clock, rising edge active
//   i_reset     - asynchronous active-high reset
//   i_start     - transaction request, only looked at while idle
//   i_baseAddr  - first beat address, captured when i_start is accepted
//   i_slowRam   - looked at only in WRITE; high inserts the delay phase
//   i_abort     - (only with RAM_SEQ_ABORT_EN) cut the burst short
//   o_read      - RAM read strobe
//   o_write     - RAM write strobe
//   o_addr      - current beat address
//   o_busy      - high in every state except IDLE
//   o_done      - one-cycle completion pulse
//
// Optional feature macro:
//   RAM_SEQ_ABORT_EN - adds the i_abort port. Abort seen at an edge in
//                      READ, WRITE or DELAY jumps straight to DONE.
// ---------------------------------------------------------------------------
module ram_rw_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int BURST_LEN   = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_baseAddr,
    input  logic              i_slowRam,
`ifdef RAM_SEQ_ABORT_EN
    input  logic              i_abort,
`endif
    output logic              o_read,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DELAY = 3'd3,
        DONE  = 3'd4
    } state_t;

    // The beat counter never exceeds BURST_LEN-1 <= 2^ADDR_W-1, so ADDR_W
    // bits are always enough for it.
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BURST_LEN - 1);
    localparam logic [7:0]        WAIT_INIT = 8'(WAIT_CYCLES - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_beat;
    logic [7:0]        r_wait;

    state_t            w_nextState;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [ADDR_W-1:0] w_nextBeat;
    logic [7:0]        w_nextWait;
    logic              w_lastBeat;
    logic              w_abort;

`ifdef RAM_SEQ_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_lastBeat = (r_beat == LAST_BEAT);

    // State and datapath registers. Reset clears everything at once, so a
    // transaction in flight is simply dropped and no Done is produced.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_beat  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_nextState;
            r_addr  <= w_nextAddr;
            r_beat  <= w_nextBeat;
            r_wait  <= w_nextWait;
        end
    end

    // Next-state and datapath update. The address advances only when moving
    // on to the following beat, so DONE keeps showing the last beat address.
    // Abort takes priority over the normal flow in the active states; the
    // strobe of the current cycle has already been issued by then.
    always_comb begin
        w_nextState = r_state;
        w_nextAddr  = r_addr;
        w_nextBeat  = r_beat;
        w_nextWait  = r_wait;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = READ;
                    w_nextAddr  = i_baseAddr;
                    w_nextBeat  = '0;
                end
            end
            READ: begin
                if (w_abort) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = WRITE;
                end
            end
            WRITE: begin
                if (w_abort) begin
                    w_nextState = DONE;
                end else if (i_slowRam) begin
                    w_nextState = DELAY;
                    w_nextWait  = WAIT_INIT;
                end else if (w_lastBeat) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = READ;
                    w_nextAddr  = r_addr + 1'b1;
                    w_nextBeat  = r_beat + 1'b1;
                end
            end
            DELAY: begin
                if (w_abort) begin
                    w_nextState = DONE;
                end else if (r_wait == 8'd0) begin
                    if (w_lastBeat) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = READ;
                        w_nextAddr  = r_addr + 1'b1;
                        w_nextBeat  = r_beat + 1'b1;
                    end
                end else begin
                    w_nextWait = r_wait - 8'd1;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state only. Unused encodings
    // fall into the default branch and keep every strobe low.
    always_comb begin
        o_read  = 1'b0;
        o_write = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            READ: begin
                o_read = 1'b1;
                o_busy = 1'b1;
            end
            WRITE: begin
                o_write = 1'b1;
                o_busy  = 1'b1;
            end
            DELAY: begin
                o_busy = 1'b1;
            end
            DONE: begin
                o_done = 1'b1;
                o_busy = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_addr = r_addr;

endmodule
